// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch sequencer: request an instruction, hold it while
// the core executes, then commit the selected next PC. Halt is terminal until reset.
//
// state  | meaning
// S_REQ  | fetch request outstanding for the instruction at PC0
// S_EXEC | IR valid, waiting for the PCWre commit pulse
// S_HALT | halted; only reset leaves this state
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PC4,
  input  logic [31:0] Imm,
  input  logic [31:0] RegAddr,
  input  logic [25:0] JumpAddr,
  input  logic        Halt,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PC0,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] IR,
  output logic        IRValid,
  output logic        AddrErr,
  output logic        Halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_EXEC = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        req_q, req_d;
  logic        addr_err_q, addr_err_d;
  logic        halted_q, halted_d;
  logic [31:0] next_pc;

  // Imm is a word offset; sums wrap modulo 2^32.
  always_comb begin
    next_pc = PC4;
    unique case (PCSrc)
      2'b00:   next_pc = PC4;
      2'b01:   next_pc = PC4 + (Imm << 2);
      2'b10:   next_pc = {RegAddr[31:2], 2'b00};
      default: next_pc = {PC4[31:28], JumpAddr, 2'b00};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    addr_err_d = addr_err_q;
    halted_d   = halted_q;
    unique case (state_q)
      S_REQ: begin
        req_d = 1'b1;
        if (IMemAck) begin
          ir_d       = IMemData;
          ir_valid_d = 1'b1;
          req_d      = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (PCWre) begin
          ir_valid_d = 1'b0;
          if (Halt) begin
            req_d    = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = S_REQ;
            if (PCSrc == 2'b10 && RegAddr[1:0] != 2'b00) addr_err_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        req_d    = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      addr_err_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      addr_err_q <= addr_err_d;
      halted_q   <= halted_d;
    end
  end

  assign PC0      = pc_q;
  assign IMemAddr = pc_q;
  assign IR       = ir_q;
  assign IRValid  = ir_valid_q;
  assign IMemReq  = req_q;
  assign AddrErr  = addr_err_q;
  assign Halted   = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch handshake, next-PC modes, sticky
// address error, halt, wrap-around and reset during an outstanding fetch.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PC4 = 32'h0;
  logic [31:0] Imm = 32'h0;
  logic [31:0] RegAddr = 32'h0;
  logic [25:0] JumpAddr = 26'h0;
  logic        Halt = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic [31:0] PC0, IMemAddr, IR;
  logic        IMemReq, IRValid, AddrErr, Halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .PC4(PC4), .Imm(Imm),
    .RegAddr(RegAddr), .JumpAddr(JumpAddr), .Halt(Halt), .IMemAck(IMemAck),
    .IMemData(IMemData), .PC0(PC0), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IR(IR), .IRValid(IRValid), .AddrErr(AddrErr), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Complete an outstanding fetch with a one-cycle ack.
  task automatic fetch(input logic [31:0] data);
    IMemAck = 1'b1;
    IMemData = data;
    cyc();
    IMemAck = 1'b0;
  endtask

  // One-cycle PCWre commit pulse.
  task automatic commit(input logic [1:0] src, input logic [31:0] pc4, input logic hlt);
    PCSrc = src;
    PC4 = pc4;
    Halt = hlt;
    PCWre = 1'b1;
    cyc();
    PCWre = 1'b0;
    Halt = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_pc0", PC0, 32'h0);
    check("rst_ir", IR, 32'h0);
    check("rst_irvalid", {31'h0, IRValid}, 32'h0);
    check("rst_req", {31'h0, IMemReq}, 32'h0);
    check("rst_addrerr", {31'h0, AddrErr}, 32'h0);
    check("rst_halted", {31'h0, Halted}, 32'h0);

    @(negedge CLK);
    RST = 1'b1;
    cyc();
    check("req_after_rst", {31'h0, IMemReq}, 32'h1);
    check("irvalid_waiting", {31'h0, IRValid}, 32'h0);
    cyc();
    check("req_held", {31'h0, IMemReq}, 32'h1);
    fetch(32'h2001_0005);
    check("fetch_ir", IR, 32'h2001_0005);
    check("fetch_irvalid", {31'h0, IRValid}, 32'h1);
    check("fetch_pc0", PC0, 32'h0);
    check("fetch_req", {31'h0, IMemReq}, 32'h0);

    fetch(32'hAAAA_5555);
    check("exec_ack_ignored", IR, 32'h2001_0005);
    Halt = 1'b1;
    cyc();
    cyc();
    Halt = 1'b0;
    check("halt_no_pcwre", {31'h0, Halted}, 32'h0);
    check("halt_no_pcwre_req", {31'h0, IMemReq}, 32'h0);

    commit(2'b00, 32'h0000_0010, 1'b0);
    check("seq_pc0", PC0, 32'h10);
    check("seq_irvalid", {31'h0, IRValid}, 32'h0);
    check("seq_req", {31'h0, IMemReq}, 32'h1);
    PCSrc = 2'b00; PC4 = 32'h0000_0999; PCWre = 1'b1;
    cyc();
    PCWre = 1'b0;
    check("req_pcwre_ignored", PC0, 32'h10);

    fetch(32'h1000_0001);
    Imm = 32'hFFFF_FFFE;
    commit(2'b01, 32'h0000_0014, 1'b0);
    check("branch_pc0", PC0, 32'h0C);
    check("branch_addr", IMemAddr, 32'h0C);
    check("branch_req", {31'h0, IMemReq}, 32'h1);

    fetch(32'h0800_0040);
    JumpAddr = 26'h000_0040;
    commit(2'b11, 32'h4000_0008, 1'b0);
    check("jump_pc0", PC0, 32'h4000_0100);

    fetch(32'h0000_0008);
    RegAddr = 32'hFFFF_FFFC;
    commit(2'b10, 32'h4000_0104, 1'b0);
    check("jr_aligned_pc0", PC0, 32'hFFFF_FFFC);
    check("jr_aligned_err", {31'h0, AddrErr}, 32'h0);

    fetch(32'h0000_0000);
    commit(2'b00, 32'h0000_0000, 1'b0);
    check("wrap_pc0", PC0, 32'h0);
    check("wrap_err", {31'h0, AddrErr}, 32'h0);

    fetch(32'h0000_0008);
    RegAddr = 32'h0000_0203;
    commit(2'b10, 32'h0000_0004, 1'b0);
    check("jr_mis_pc0", PC0, 32'h200);
    check("jr_mis_err", {31'h0, AddrErr}, 32'h1);

    fetch(32'h0000_0000);
    commit(2'b00, 32'h0000_0204, 1'b0);
    check("err_sticky", {31'h0, AddrErr}, 32'h1);
    check("post_err_pc0", PC0, 32'h204);

    fetch(32'h0000_000D);
    commit(2'b00, 32'h0000_0208, 1'b1);
    check("halt_pc0", PC0, 32'h204);
    check("halt_halted", {31'h0, Halted}, 32'h1);
    check("halt_irvalid", {31'h0, IRValid}, 32'h0);
    check("halt_req", {31'h0, IMemReq}, 32'h0);
    commit(2'b00, 32'h0000_0300, 1'b0);
    fetch(32'hBAD0_BAD0);
    commit(2'b11, 32'h0000_0400, 1'b0);
    check("halt_hold_pc0", PC0, 32'h204);
    check("halt_hold_ir", IR, 32'h0000_000D);
    check("halt_hold_halted", {31'h0, Halted}, 32'h1);
    check("halt_hold_req", {31'h0, IMemReq}, 32'h0);

    RST = 1'b0;
    #1;
    check("rst2_pc0", PC0, 32'h0);
    check("rst2_halted", {31'h0, Halted}, 32'h0);
    check("rst2_err", {31'h0, AddrErr}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    cyc();
    check("rst2_req", {31'h0, IMemReq}, 32'h1);
    #2;
    RST = 1'b0;
    IMemAck = 1'b1;
    IMemData = 32'hDEAD_BEEF;
    #1;
    check("midfetch_req", {31'h0, IMemReq}, 32'h0);
    check("midfetch_pc0", PC0, 32'h0);
    cyc();
    check("late_ack_ir", IR, 32'h0);
    check("late_ack_irvalid", {31'h0, IRValid}, 32'h0);
    IMemAck = 1'b0;
    RST = 1'b1;
    cyc();
    check("rst3_req", {31'h0, IMemReq}, 32'h1);
    check("rst3_ir", IR, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
